mmio_bridge: RTL and testbench

Memory/IO bridge sitting directly downstream of the `cpu` top-level byte bus (`mem_a`/`mem_dout`/`mem_wr`/`mem_din`/`io_buffer_full`). It decodes every CPU byte access and routes it either to the 128 KB single-port RAM or to the IO space at `0x30000`. The IO space covers:

- the UART TX FIFO;
- the UART RX byte port;
- the free-running cycle counter at `0x30004`;
- the program-stop latch.

It generates `io_buffer_full` back to the CPU and returns read data with the fixed one-cycle latency the CPU expects.

---
 rtl/mmio_bridge.sv | 169 ++++++++++++++++
 tb/tb_mmio_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// Byte-bus bridge between the CPU and the RAM / IO space at 0x30000.
// IO space holds the UART TX FIFO, the RX byte port, a free-running cycle counter and the stop latch.
module mmio_bridge #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_FIFO_WIDTH  = 3
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic [31:0]               cpu_mem_a,
    input  logic [7:0]                cpu_mem_dout,
    input  logic                      cpu_mem_wr,
    output logic [7:0]                cpu_mem_din,
    output logic                      io_buffer_full,
    output logic                      ram_en,
    output logic                      ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]                ram_din,
    input  logic [7:0]                ram_dout,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_pop,
    output logic                      program_finished,
    output logic                      tx_overflow
);

    localparam int DEPTH = 1 << TX_FIFO_WIDTH;
    localparam logic [TX_FIFO_WIDTH:0] FULL_CNT = (TX_FIFO_WIDTH + 1)'(DEPTH);
    localparam logic [TX_FIFO_WIDTH:0] HIGH_CNT = (TX_FIFO_WIDTH + 1)'(DEPTH - 1);

    logic       acc_vld;
    logic       io_sel;
    logic       io_rd;
    logic       io_wr;
    logic [2:0] io_off;
    logic       unused_hi_addr;

    logic                   ret_sel_q, ret_sel_d;
    logic [7:0]             io_rdata_q, io_rdata_d;
    logic [31:0]            snap_q, snap_d;
    logic [31:0]            cycle_cnt_q, cycle_cnt_d;
    logic [TX_FIFO_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [TX_FIFO_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                   full_q, full_d;
    logic                   finished_q, finished_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             fifo_mem_q [DEPTH];

    logic [TX_FIFO_WIDTH:0] fill;
    logic [TX_FIFO_WIDTH:0] fill_next;
    logic                   fifo_full;
    logic                   push_req;
    logic                   push_ok;
    logic                   pop;
    logic [7:0]             push_byte;

    assign unused_hi_addr = ^cpu_mem_a[31:18];

    // Reset masks the CPU side so nothing leaks to RAM or the RX port during reset.
    assign acc_vld = rdy_in & ~rst_in;
    assign io_sel  = (cpu_mem_a[17:16] == 2'b11);
    assign io_off  = cpu_mem_a[2:0];
    assign io_rd   = acc_vld & io_sel & ~cpu_mem_wr;
    assign io_wr   = acc_vld & io_sel & cpu_mem_wr;

    assign ram_en   = acc_vld & ~io_sel;
    assign ram_wr   = ram_en & cpu_mem_wr;
    assign ram_addr = rst_in ? '0 : cpu_mem_a[RAM_ADDR_WIDTH-1:0];
    assign ram_din  = rst_in ? 8'h00 : cpu_mem_dout;

    assign rx_pop = io_rd & (io_off == 3'd0) & rx_valid;

    assign cpu_mem_din = ret_sel_q ? io_rdata_q : ram_dout;

    assign fill      = wr_ptr_q - rd_ptr_q;
    assign fifo_full = (fill == FULL_CNT);
    assign tx_valid  = (wr_ptr_q != rd_ptr_q);
    assign tx_data   = fifo_mem_q[rd_ptr_q[TX_FIFO_WIDTH-1:0]];
    assign pop       = tx_valid & tx_ready;
    assign push_ok   = push_req & (~fifo_full | pop);

    assign io_buffer_full   = full_q;
    assign program_finished = finished_q;
    assign tx_overflow      = overflow_q;

    always_comb begin
        push_req    = 1'b0;
        push_byte   = 8'h00;
        finished_d  = finished_q;
        overflow_d  = overflow_q;
        ret_sel_d   = ret_sel_q;
        io_rdata_d  = io_rdata_q;
        snap_d      = snap_q;
        cycle_cnt_d = cycle_cnt_q + 32'd1;

        if (io_wr) begin
            if (io_off == 3'd0 && cpu_mem_dout != 8'h00) begin
                push_req  = 1'b1;
                push_byte = cpu_mem_dout;
            end else if (io_off == 3'd4) begin
                push_req   = 1'b1;
                push_byte  = 8'h00;
                finished_d = 1'b1;
            end
        end

        if (acc_vld && !cpu_mem_wr) begin
            ret_sel_d = io_sel;
            if (io_sel) begin
                case (io_off)
                    3'd0:    io_rdata_d = rx_valid ? rx_data : 8'h00;
                    3'd4: begin
                        // Snapshot with byte 0 so the upper bytes read later are coherent.
                        snap_d     = cycle_cnt_q;
                        io_rdata_d = cycle_cnt_q[7:0];
                    end
                    3'd5:    io_rdata_d = snap_q[15:8];
                    3'd6:    io_rdata_d = snap_q[23:16];
                    3'd7:    io_rdata_d = snap_q[31:24];
                    default: io_rdata_d = 8'h00;
                endcase
            end
        end

        if (push_req && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        wr_ptr_d  = wr_ptr_q + {{TX_FIFO_WIDTH{1'b0}}, push_ok};
        rd_ptr_d  = rd_ptr_q + {{TX_FIFO_WIDTH{1'b0}}, pop};
        fill_next = wr_ptr_d - rd_ptr_d;
        // One slot of margin: the CPU sees the flag a cycle late and may push once more.
        full_d    = (fill_next >= HIGH_CNT);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ret_sel_q   <= 1'b1;
            io_rdata_q  <= 8'h00;
            snap_q      <= 32'd0;
            cycle_cnt_q <= 32'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            finished_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ret_sel_q   <= ret_sel_d;
            io_rdata_q  <= io_rdata_d;
            snap_q      <= snap_d;
            cycle_cnt_q <= cycle_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            finished_q  <= finished_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q[TX_FIFO_WIDTH-1:0]] <= push_byte;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed and randomized bench for mmio_bridge against a queue-based reference model.
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst, rdy, wr, tx_ready, rx_valid;
    logic [31:0] a;
    logic [7:0]  dout, rx_data;
    logic [7:0]  cpu_mem_din, ram_din, tx_data;
    logic [7:0]  ram_dout = 8'h00;
    logic [16:0] ram_addr;
    logic        io_buffer_full, ram_en, ram_wr, tx_valid, rx_pop, program_finished, tx_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mmio_bridge dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .cpu_mem_a(a), .cpu_mem_dout(dout), .cpu_mem_wr(wr), .cpu_mem_din(cpu_mem_din),
        .io_buffer_full(io_buffer_full),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .program_finished(program_finished), .tx_overflow(tx_overflow)
    );

    // Single-port RAM with one cycle of read latency.
    bit [7:0] ram_arr [0:131071];
    always @(posedge clk) begin
        if (ram_en && ram_wr) ram_arr[ram_addr] <= ram_din;
        if (ram_en && !ram_wr) ram_dout <= ram_arr[ram_addr];
    end

    // Reference model state.
    byte unsigned ref_ram [int];
    bit [7:0]     txq [$];
    bit [7:0]     dut_drained [$];
    bit [31:0]    m_cnt, m_snap;
    bit [7:0]     m_din;
    bit           m_fin, m_ovf, m_full;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit       v, io;
        bit [2:0] off;
        int       idx;
        #1;
        v   = !rst && rdy;
        io  = (a[17:16] == 2'b11);
        off = a[2:0];
        chk("ram_en", ram_en, v && !io);
        chk("ram_wr", ram_wr, v && !io && wr);
        chk("ram_addr", ram_addr, rst ? 32'd0 : {15'd0, a[16:0]});
        if (!rst) chk("ram_din", ram_din, dout);
        chk("rx_pop", rx_pop, v && io && !wr && off == 3'd0 && rx_valid);
        if (tx_valid && tx_ready) dut_drained.push_back(tx_data);

        if (rst) begin
            txq.delete();
            m_cnt = 0; m_snap = 0; m_din = 0;
            m_fin = 0; m_ovf = 0; m_full = 0;
        end else begin
            bit       push = 0;
            bit [7:0] pb   = 0;
            idx = int'(a[16:0]);
            if (v && io && wr) begin
                if (off == 3'd0 && dout != 8'h00) begin push = 1; pb = dout; end
                else if (off == 3'd4) begin push = 1; pb = 8'h00; m_fin = 1; end
            end
            if (v && !io && wr) ref_ram[idx] = dout;
            if (v && !wr) begin
                if (!io) m_din = ref_ram.exists(idx) ? 8'(ref_ram[idx]) : 8'h00;
                else begin
                    case (off)
                        3'd0: m_din = rx_valid ? rx_data : 8'h00;
                        3'd4: begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
                        3'd5: m_din = m_snap[15:8];
                        3'd6: m_din = m_snap[23:16];
                        3'd7: m_din = m_snap[31:24];
                        default: m_din = 8'h00;
                    endcase
                end
            end
            if (txq.size() > 0 && tx_ready) void'(txq.pop_front());
            if (push) begin
                if (txq.size() < 8) txq.push_back(pb);
                else m_ovf = 1;
            end
            m_full = (txq.size() >= 7);
            m_cnt  = m_cnt + 32'd1;
        end

        @(posedge clk);
        #1;
        chk("cpu_mem_din", cpu_mem_din, m_din);
        chk("io_buffer_full", io_buffer_full, m_full);
        chk("program_finished", program_finished, m_fin);
        chk("tx_overflow", tx_overflow, m_ovf);
        chk("tx_valid", tx_valid, txq.size() > 0);
        if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rdy = 0; wr = 0; a = 32'd0; dout = 8'd0;
            tick();
        end
    endtask

    task automatic bus(input bit w, input logic [31:0] addr, input logic [7:0] d);
        rdy = 1; wr = w; a = addr; dout = d;
        tick();
    endtask

    task automatic do_reset();
        rst = 1; rdy = 0; wr = 0; a = 32'd0; dout = 8'd0;
        tick();
        rst = 0;
    endtask

    initial begin
        logic [7:0] b0, b1, b2, b3;
        rst = 1; rdy = 0; wr = 0; a = 0; dout = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;
        tick();
        do_reset();
        chk("reset_din", cpu_mem_din, 8'h00);
        chk("reset_tx_valid", tx_valid, 1'b0);

        // RAM write then read back
        bus(1, 32'h0000_0010, 8'hA5);
        bus(0, 32'h0000_0010, 8'h00);
        chk("ram_rd_a5", cpu_mem_din, 8'hA5);
        idle(1);
        chk("ram_rd_hold", cpu_mem_din, 8'hA5);

        // TX write with a zero byte that must be skipped
        tx_ready = 1;
        dut_drained.delete();
        bus(1, 32'h0003_0000, 8'h41);
        bus(1, 32'h0003_0000, 8'h00);
        bus(1, 32'h0003_0000, 8'h42);
        idle(3);
        chk("tx_drain_cnt", dut_drained.size(), 2);
        if (dut_drained.size() == 2) begin
            chk("tx_drain_0", dut_drained[0], 8'h41);
            chk("tx_drain_1", dut_drained[1], 8'h42);
        end
        chk("tx_empty", tx_valid, 1'b0);

        // Fill to full, then overflow
        tx_ready = 0;
        for (int i = 1; i <= 6; i++) bus(1, 32'h0003_0000, 8'(i));
        chk("full_after_6", io_buffer_full, 1'b0);
        bus(1, 32'h0003_0000, 8'd7);
        chk("full_after_7", io_buffer_full, 1'b1);
        bus(1, 32'h0003_0000, 8'd8);
        chk("no_ovf_after_8", tx_overflow, 1'b0);
        bus(1, 32'h0003_0000, 8'd9);
        chk("ovf_after_9", tx_overflow, 1'b1);
        tx_ready = 1;
        dut_drained.delete();
        idle(10);
        chk("full_drain_cnt", dut_drained.size(), 8);
        for (int i = 0; i < dut_drained.size() && i < 8; i++)
            chk("full_drain_byte", dut_drained[i], 32'(i + 1));

        // Cycle counter coherence
        do_reset();
        idle(100);
        bus(0, 32'h0003_0004, 8'h00); b0 = cpu_mem_din; idle(2);
        bus(0, 32'h0003_0005, 8'h00); b1 = cpu_mem_din; idle(3);
        bus(0, 32'h0003_0006, 8'h00); b2 = cpu_mem_din; idle(1);
        bus(0, 32'h0003_0007, 8'h00); b3 = cpu_mem_din;
        chk("cnt_snapshot", {b3, b2, b1, b0}, 32'd100);

        // Program stop and RX
        tx_ready = 0;
        bus(1, 32'h0003_0004, 8'h99);
        chk("prog_finished", program_finished, 1'b1);
        chk("stop_tx_valid", tx_valid, 1'b1);
        chk("stop_tx_zero", tx_data, 8'h00);
        rx_valid = 1; rx_data = 8'h37;
        rdy = 1; wr = 0; a = 32'h0003_0000;
        #1;
        chk("rx_pop_pulse", rx_pop, 1'b1);
        tick();
        chk("rx_data_ret", cpu_mem_din, 8'h37);
        rx_valid = 0;
        bus(0, 32'h0003_0000, 8'h00);
        chk("rx_empty_ret", cpu_mem_din, 8'h00);

        // Stalled write must not push
        rdy = 0; wr = 1; a = 32'h0003_0000; dout = 8'h55;
        #1;
        chk("stall_ram_en", ram_en, 1'b0);
        tick();
        tx_ready = 1;
        dut_drained.delete();
        idle(3);
        chk("stall_drain_cnt", dut_drained.size(), 1);
        if (dut_drained.size() == 1) chk("stall_drain_byte", dut_drained[0], 8'h00);

        // Reset with bytes queued
        tx_ready = 0;
        bus(1, 32'h0003_0000, 8'h11);
        bus(1, 32'h0003_0000, 8'h22);
        bus(1, 32'h0003_0004, 8'h00);
        chk("queued_valid", tx_valid, 1'b1);
        do_reset();
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_finished", program_finished, 1'b0);
        chk("rst_overflow", tx_overflow, 1'b0);
        chk("rst_full", io_buffer_full, 1'b0);
        chk("rst_din", cpu_mem_din, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 149) == 0);
            rdy      = ($urandom_range(0, 3) != 0);
            wr       = $urandom_range(0, 1);
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = $urandom_range(0, 1);
            rx_data  = 8'($urandom);
            dout     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 1) == 1)
                a = {14'($urandom), 2'b11, 13'($urandom), 3'($urandom)};
            else
                a = {14'($urandom), 2'($urandom_range(0, 2)), 12'd0, 4'($urandom)};
            tick();
        end
        rst = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
